sdram_scan_reader: RTL

//  Read-agent client of the sdram controller's RdReq/RdGnt/RdAddr/RdData/RdDataValid port.
//  On a start pulse it streams LEN consecutive words from BASE_ADDR (e.g. Hack screen map)

---
 rtl/sdram_scan_reader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sdram_scan_reader.sv
// sdram_scan_reader: read-agent client of the sdram controller.
// A start pulse streams LEN consecutive words from BASE_ADDR into a small
// first-word-fall-through FIFO that feeds a valid/ready pixel stream.
// Reads are only issued while buffered words plus in-flight reads fit in
// the FIFO, so a returning word always has a free slot.
module sdram_scan_reader #(
  parameter logic [19:0] BASE_ADDR    = 20'h04000,
  parameter int          LEN          = 8192,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          FLUSH_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        RdReq,
  input  logic        RdGnt,
  output logic [19:0] RdAddr,
  input  logic [15:0] RdData,
  input  logic        RdDataValid,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready
);

  localparam int IDX_W = $clog2(LEN + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FL_W  = $clog2(FLUSH_CYCLES);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LEN - 1);
  localparam logic [IDX_W-1:0] LEN_CNT   = IDX_W'(LEN);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [FL_W-1:0]  FLUSH_TOP = FL_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_FLUSH,
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] popped;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [FL_W-1:0]  flush_cnt;
  logic [15:0]      mem [FIFO_DEPTH];

  logic [CNT_W:0] credit_used;
  logic           grant;
  logic           accepting;
  logic           push_req;
  logic           fifo_full;
  logic           push;
  logic           pop;
  logic           scan_start;

  // Credit is counted against the FIFO depth with one extra bit so the sum cannot wrap.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
  assign grant       = RdReq & RdGnt;
  assign accepting   = (state == S_FETCH) || (state == S_DRAIN);
  assign push_req    = RdDataValid & accepting;
  assign fifo_full   = (fifo_count == DEPTH_CNT);
  assign push        = push_req & ~fifo_full;
  assign pop         = pix_valid & pix_ready;
  assign scan_start  = (state == S_IDLE) & start;

  assign RdAddr    = BASE_ADDR + 20'(idx);
  assign pix_valid = (fifo_count != '0);
  assign pix_data  = mem[rd_ptr];

  // State register; reset always lands in FLUSH so stale returns are absorbed.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FLUSH;
    else     state <= state_next;
  end

  // Next-state and control outputs; RdReq depends only on registered counters.
  always_comb begin
    state_next = state;
    RdReq      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_FLUSH: begin
        if (flush_cnt == '0) state_next = S_IDLE;
      end
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        RdReq = (credit_used < DEPTH_EXT);
        if ((credit_used < DEPTH_EXT) && RdGnt && (idx == LAST_IDX)) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (popped == LEN_CNT) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_FLUSH;
    endcase
  end

  // Post-reset flush countdown; holds at zero once FLUSH is over.
  always_ff @(posedge clk) begin
    if (rst)                                    flush_cnt <= FLUSH_TOP;
    else if (state == S_FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - FL_W'(1);
  end

  // Request index advances once per accepted grant and restarts on each scan.
  always_ff @(posedge clk) begin
    if (rst)             idx <= '0;
    else if (scan_start) idx <= '0;
    else if (grant)      idx <= idx + IDX_W'(1);
  end

  // Words handed to the stream consumer during the current scan.
  always_ff @(posedge clk) begin
    if (rst)             popped <= '0;
    else if (scan_start) popped <= '0;
    else if (pop)        popped <= popped + IDX_W'(1);
  end

  // In-flight reads: up on a grant, down on a return, unchanged when both coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else if (grant && !push_req) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (!grant && push_req && outstanding != '0) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
    end
  end

  // FIFO storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= RdData;
  end

  // Sticky flag for a return that found the FIFO full; the word itself is dropped.
  always_ff @(posedge clk) begin
    if (rst)                        overflow <= 1'b0;
    else if (push_req && fifo_full) overflow <= 1'b1;
  end

endmodule
